// File: rtl/instr_fetch_assembler.sv
// Byte-wide instruction fetch: walks a PC through a synchronous byte memory and
// packs BYTES_PER_INSTR consecutive bytes (first byte in the MSBs) into one word.
module instr_fetch_assembler #(
  parameter int ADDR_W          = 8,
  parameter int BYTE_W          = 8,
  parameter int BYTES_PER_INSTR = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_jump_valid,
  input  logic [ADDR_W-1:0]                 i_jump_addr,
  output logic [ADDR_W-1:0]                 o_mem_addr,
  output logic                              o_mem_rden,
  input  logic [BYTE_W-1:0]                 i_mem_rdata,
  output logic                              o_instr_valid,
  input  logic                              i_instr_ready,
  output logic [BYTE_W*BYTES_PER_INSTR-1:0] o_instr_data,
  output logic [ADDR_W-1:0]                 o_instr_pc
);

  localparam int WORD_W = BYTE_W * BYTES_PER_INSTR;
  localparam int CNT_W  = $clog2(BYTES_PER_INSTR + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BYTES_PER_INSTR - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BYTES_PER_INSTR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } FetchState;

  FetchState          r_state;
  FetchState          w_stateNext;

  logic [ADDR_W-1:0]  r_reqAddr;
  logic [CNT_W-1:0]   r_issCnt;
  logic [CNT_W-1:0]   r_rxCnt;
  logic               r_rdPending;
  logic [WORD_W-1:0]  r_asmWord;
  logic [ADDR_W-1:0]  r_asmPc;
  logic               r_outValid;
  logic [WORD_W-1:0]  r_outData;
  logic [ADDR_W-1:0]  r_outPc;

  logic               w_issue;
  logic               w_load;
  logic [WORD_W-1:0]  w_loadWord;
  logic [WORD_W-1:0]  w_shifted;
  logic               w_lastCapture;
  logic               w_slotFree;

  // The byte arriving this cycle completes the word when it is the last one.
  assign w_shifted     = {r_asmWord[WORD_W-BYTE_W-1:0], i_mem_rdata};
  assign w_lastCapture = r_rdPending && (r_rxCnt == CNT_LAST);
  assign w_slotFree    = !r_outValid || i_instr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A jump suppresses issue and loading; the datapath block clears the rest.
  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_loadWord  = w_shifted;
    if (i_jump_valid) begin
      w_stateNext = FILL;
    end else begin
      case (r_state)
        FILL: begin
          w_issue = (r_issCnt < CNT_FULL);
          if (w_lastCapture) begin
            if (w_slotFree) begin
              w_load = 1'b1;
            end else begin
              w_stateNext = FULL;
            end
          end
        end
        FULL: begin
          w_loadWord = r_asmWord;
          if (w_slotFree) begin
            w_load      = 1'b1;
            w_stateNext = FILL;
          end
        end
        default: begin
          w_stateNext = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reqAddr   <= '0;
      r_issCnt    <= CNT_ZERO;
      r_rxCnt     <= CNT_ZERO;
      r_rdPending <= 1'b0;
      r_asmWord   <= '0;
      r_asmPc     <= '0;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outPc     <= '0;
    end else if (i_jump_valid) begin
      r_reqAddr   <= i_jump_addr;
      r_issCnt    <= CNT_ZERO;
      r_rxCnt     <= CNT_ZERO;
      r_rdPending <= 1'b0;
      r_outValid  <= 1'b0;
    end else begin
      r_rdPending <= w_issue;
      if (w_issue) begin
        r_reqAddr <= r_reqAddr + ADDR_ONE;
        r_issCnt  <= r_issCnt + CNT_ONE;
        if (r_issCnt == CNT_ZERO) begin
          r_asmPc <= r_reqAddr;
        end
      end
      if (r_rdPending) begin
        r_asmWord <= w_shifted;
        r_rxCnt   <= r_rxCnt + CNT_ONE;
      end
      // Loading a word restarts assembly; it overrides the counter updates above.
      if (w_load) begin
        r_outValid <= 1'b1;
        r_outData  <= w_loadWord;
        r_outPc    <= r_asmPc;
        r_issCnt   <= CNT_ZERO;
        r_rxCnt    <= CNT_ZERO;
      end else if (r_outValid && i_instr_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign o_mem_addr    = r_reqAddr;
  assign o_mem_rden    = w_issue;
  assign o_instr_valid = r_outValid;
  assign o_instr_data  = r_outData;
  assign o_instr_pc    = r_outPc;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Bench for instr_fetch_assembler: directed timing tables on a 4-byte/8-bit-address
// instance, wrap checks on a 2-byte/10-bit-address instance, then random traffic.
module tb_instr_fetch_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN = 1'b0;

  logic        jumpValidA = 1'b0;
  logic [7:0]  jumpAddrA  = '0;
  logic [7:0]  memAddrA;
  logic        memRdenA;
  logic [7:0]  memRdataA  = '0;
  logic        validA;
  logic        readyA     = 1'b0;
  logic [31:0] dataA;
  logic [7:0]  pcA;

  logic        jumpValidB = 1'b0;
  logic [9:0]  jumpAddrB  = '0;
  logic [9:0]  memAddrB;
  logic        memRdenB;
  logic [7:0]  memRdataB  = '0;
  logic        validB;
  logic        readyB     = 1'b0;
  logic [15:0] dataB;
  logic [9:0]  pcB;

  int errors = 0;
  int checks = 0;

  instr_fetch_assembler #(.ADDR_W(8), .BYTE_W(8), .BYTES_PER_INSTR(4)) dutA (
    .i_clk(clk), .i_rst_n(rstN),
    .i_jump_valid(jumpValidA), .i_jump_addr(jumpAddrA),
    .o_mem_addr(memAddrA), .o_mem_rden(memRdenA), .i_mem_rdata(memRdataA),
    .o_instr_valid(validA), .i_instr_ready(readyA),
    .o_instr_data(dataA), .o_instr_pc(pcA)
  );

  instr_fetch_assembler #(.ADDR_W(10), .BYTE_W(8), .BYTES_PER_INSTR(2)) dutB (
    .i_clk(clk), .i_rst_n(rstN),
    .i_jump_valid(jumpValidB), .i_jump_addr(jumpAddrB),
    .o_mem_addr(memAddrB), .o_mem_rden(memRdenB), .i_mem_rdata(memRdataB),
    .o_instr_valid(validB), .i_instr_ready(readyB),
    .o_instr_data(dataB), .o_instr_pc(pcB)
  );

  // Memory contents: A holds byte i at address i; B folds the top address bits in
  // so that the bytes on either side of the 0x3FF wrap are distinguishable.
  function automatic logic [7:0] memByteA(input logic [7:0] a);
    return a;
  endfunction

  function automatic logic [7:0] memByteB(input logic [9:0] a);
    return a[7:0] ^ {6'b0, a[9:8]};
  endfunction

  function automatic logic [31:0] wordA(input logic [7:0] pc);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w = {w[23:0], memByteA(pc + 8'(i))};
    return w;
  endfunction

  function automatic logic [15:0] wordB(input logic [9:0] pc);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 2; i++) w = {w[7:0], memByteB(pc + 10'(i))};
    return w;
  endfunction

  always @(posedge clk) begin
    if (memRdenA) memRdataA <= memByteA(memAddrA);
    if (memRdenB) memRdataB <= memByteB(memAddrB);
  end

  typedef struct {
    logic        jump;
    logic [7:0]  jumpAddr;
    logic        ready;
    logic        expRden;
    logic        expValid;
    logic [31:0] expData;
    logic [7:0]  expPc;
  } VecA;

  VecA startVecs[11];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input VecA v);
    jumpValidA = v.jump;
    jumpAddrA  = v.jumpAddr;
    readyA     = v.ready;
  endtask

  task automatic checkOutput(input VecA v, input string tag);
    check({tag, ".rden"}, memRdenA, v.expRden);
    check({tag, ".valid"}, validA, v.expValid);
    if (v.expValid) begin
      check({tag, ".data"}, dataA, v.expData);
      check({tag, ".pc"}, pcA, v.expPc);
    end
  endtask

  task automatic stepA(input logic jump, input logic [7:0] addr, input logic ready);
    VecA v;
    v = '{jump, addr, ready, 1'b0, 1'b0, 32'h0, 8'h0};
    applyStimulus(v);
    @(negedge clk);
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: just after the edge that follows reset release.
  task automatic resetDut();
    jumpValidA = 1'b0; readyA = 1'b0;
    jumpValidB = 1'b0; readyB = 1'b0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.A.valid", validA, 1'b0);
    check("reset.A.data", dataA, 32'h0);
    check("reset.A.pc", pcA, 8'h0);
    check("reset.A.memAddr", memAddrA, 8'h0);
    check("reset.B.valid", validB, 1'b0);
    check("reset.B.pc", pcB, 10'h0);
    rstN = 1'b1;
  endtask

  task automatic runStartTable(input string tag);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(startVecs[k]);
      @(negedge clk);
      checkOutput(startVecs[k], $sformatf("%s[%0d]", tag, k));
      endCycle();
    end
  endtask

  int rdCount;
  int unstable;
  int deliveredA;
  int deliveredB;
  logic [7:0] expPcA;
  logic [9:0] expPcB;

  initial begin
    // Ready held high from release: words at cycles 5 and 10, one issue gap each.
    startVecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        8'h00};
    startVecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        8'h00};
    startVecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        8'h00};
    startVecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        8'h00};
    startVecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        8'h00};
    startVecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h00010203, 8'h00};
    startVecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        8'h00};
    startVecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        8'h00};
    startVecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        8'h00};
    startVecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        8'h00};
    startVecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h04050607, 8'h04};

    resetDut();
    runStartTable("start");

    // Backpressure: first word must hold while the second assembles and parks.
    resetDut();
    rdCount = 0;
    unstable = 0;
    for (int c = 0; c < 25; c++) begin
      stepA(1'b0, 8'h00, 1'b0);
      if (c >= 5) begin
        if (memRdenA) rdCount++;
        if (!(validA === 1'b1 && dataA === 32'h00010203 && pcA === 8'h00)) unstable++;
      end
      endCycle();
    end
    check("bp.readsWhileStalled", 64'(rdCount), 64'd4);
    check("bp.unstableCycles", 64'(unstable), 64'd0);
    stepA(1'b0, 8'h00, 1'b1);
    check("bp.firstWordAtRelease", dataA, 32'h00010203);
    endCycle();
    stepA(1'b0, 8'h00, 1'b0);
    check("bp.secondValid", validA, 1'b1);
    check("bp.secondData", dataA, 32'h04050607);
    check("bp.secondPc", pcA, 8'h04);
    endCycle();

    // Jump with two bytes assembled and a word pending at the output.
    stepA(1'b0, 8'h00, 1'b0); endCycle();
    stepA(1'b0, 8'h00, 1'b0); endCycle();
    stepA(1'b1, 8'h80, 1'b0);
    check("jmp80.rdenInJumpCycle", memRdenA, 1'b0);
    check("jmp80.validInJumpCycle", validA, 1'b1);
    endCycle();
    for (int c = 1; c <= 6; c++) begin
      stepA(1'b0, 8'h00, 1'b1);
      if (c == 1) begin
        check("jmp80.validDropped", validA, 1'b0);
        check("jmp80.memAddr", memAddrA, 8'h80);
        check("jmp80.rdenResumes", memRdenA, 1'b1);
      end
      if (c == 5) check("jmp80.validEarly", validA, 1'b0);
      if (c == 6) begin
        check("jmp80.valid", validA, 1'b1);
        check("jmp80.data", dataA, 32'h80818283);
        check("jmp80.pc", pcA, 8'h80);
      end
      endCycle();
    end

    // Address wrap within a word at the top of an 8-bit space.
    stepA(1'b1, 8'hFE, 1'b1); endCycle();
    for (int c = 1; c <= 11; c++) begin
      stepA(1'b0, 8'h00, 1'b1);
      if (c == 6) begin
        check("wrapA.data", dataA, 32'hFEFF0001);
        check("wrapA.pc", pcA, 8'hFE);
      end
      if (c == 10) check("wrapA.gap", validA, 1'b0);
      if (c == 11) begin
        check("wrapA.nextData", dataA, 32'h02030405);
        check("wrapA.nextPc", pcA, 8'h02);
      end
      endCycle();
    end

    // Asynchronous reset in the middle of a cycle with a word held at the output.
    for (int c = 0; c < 8; c++) begin
      stepA(1'b0, 8'h00, 1'b0);
      endCycle();
    end
    check("async.validBefore", validA, 1'b1);
    #2 rstN = 1'b0;
    #1;
    check("async.valid", validA, 1'b0);
    check("async.data", dataA, 32'h0);
    check("async.pc", pcA, 8'h0);
    check("async.memAddr", memAddrA, 8'h0);
    check("async.B.valid", validB, 1'b0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    runStartTable("restart");

    // Two-byte words on a 10-bit address space, including the 0x3FF wrap.
    resetDut();
    for (int c = 0; c < 15; c++) begin
      jumpValidB = (c == 7);
      jumpAddrB  = 10'h3FE;
      readyB     = 1'b1;
      @(negedge clk);
      if (c == 2) check("B.rdenGap", memRdenB, 1'b0);
      if (c == 3) begin
        check("B.first.data", dataB, 16'h0001);
        check("B.first.pc", pcB, 10'h000);
      end
      if (c == 4 || c == 5) check($sformatf("B.gap[%0d]", c), validB, 1'b0);
      if (c == 6) begin
        check("B.second.data", dataB, 16'h0203);
        check("B.second.pc", pcB, 10'h002);
      end
      if (c == 7) check("B.rdenInJump", memRdenB, 1'b0);
      if (c == 10) check("B.jumpEarly", validB, 1'b0);
      if (c == 11) begin
        check("B.wrap.data", dataB, 16'hFDFC);
        check("B.wrap.pc", pcB, 10'h3FE);
      end
      if (c == 14) begin
        check("B.afterWrap.data", dataB, 16'h0001);
        check("B.afterWrap.pc", pcB, 10'h000);
      end
      endCycle();
    end
    jumpValidB = 1'b0;

    // Random traffic against a stream model: after reset or a jump, words are the
    // consecutive N-byte groups starting at that address, delivered in order.
    resetDut();
    expPcA = 8'h00;
    expPcB = 10'h000;
    deliveredA = 0;
    deliveredB = 0;
    for (int c = 0; c < 3000; c++) begin
      readyA     = ($urandom_range(0, 9) < 7);
      jumpValidA = ($urandom_range(0, 99) < 3);
      jumpAddrA  = 8'($urandom);
      readyB     = ($urandom_range(0, 9) < 7);
      jumpValidB = ($urandom_range(0, 99) < 3);
      jumpAddrB  = 10'($urandom);
      @(negedge clk);
      if (validA) begin
        check("rand.A.data", dataA, wordA(expPcA));
        check("rand.A.pc", pcA, expPcA);
        if (readyA) begin
          expPcA = expPcA + 8'd4;
          deliveredA++;
        end
      end
      if (jumpValidA) begin
        check("rand.A.rdenOnJump", memRdenA, 1'b0);
        expPcA = jumpAddrA;
      end
      if (validB) begin
        check("rand.B.data", dataB, wordB(expPcB));
        check("rand.B.pc", pcB, expPcB);
        if (readyB) begin
          expPcB = expPcB + 10'd2;
          deliveredB++;
        end
      end
      if (jumpValidB) begin
        check("rand.B.rdenOnJump", memRdenB, 1'b0);
        expPcB = jumpAddrB;
      end
      endCycle();
    end
    check("rand.A.progress", 64'(deliveredA >= 50), 64'd1);
    check("rand.B.progress", 64'(deliveredB >= 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_assembler.md
# instr_fetch_assembler

Parametrised instruction fetch unit between a byte-wide synchronous instruction memory and the decoder. It walks a program counter through memory and packs BYTES_PER_INSTR consecutive bytes into one instruction word, first byte in the MSBs. Each word goes out on a valid/ready port together with its start address. A one-cycle jump request redirects fetch to a new address and flushes every partially or fully assembled instruction.

## Interface
- ADDR_W, 8: instruction memory address width; PC wraps modulo 2^ADDR_W.
- BYTE_W, 8: memory word width.
- BYTES_PER_INSTR, 4: bytes per instruction, at least 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- jump_valid  in  1  one-cycle redirect request.
- jump_addr  in  ADDR_W  new fetch address, sampled when jump_valid=1.
- mem_addr  out  ADDR_W  registered read address.
- mem_rden  out  1  read issued this cycle; combinational.
- mem_rdata  in  BYTE_W  read data, valid exactly one cycle after the matching mem_rden.
- instr_valid  out  1  instr_data/instr_pc hold a complete instruction.
- instr_ready  in  1  consumer accepts when instr_valid & instr_ready.
- instr_data  out  BYTE_W*BYTES_PER_INSTR  assembled instruction; byte 0 in the MSBs.
- instr_pc  out  ADDR_W  address of byte 0 of instr_data.

## Operation
- Registers:
  - req_addr, drives mem_addr.
  - iss_cnt and rx_cnt, each 0..BYTES_PER_INSTR.
  - rd_pending.
  - asm_word: shift register, shifts left by BYTE_W and inserts mem_rdata in the LSBs.
  - asm_pc.
  - Output register: instr_valid, instr_data, instr_pc.
- States:
  - FILL: issuing and capturing bytes.
  - FULL: complete word waiting for the output slot.
- Issue: mem_rden = (state==FILL) & (iss_cnt<BYTES_PER_INSTR) & !jump_valid. On issue, req_addr+1 (wraps) and iss_cnt+1. When iss_cnt==0, asm_pc<=req_addr.
- Capture: whenever rd_pending=1, mem_rdata shifts into asm_word and rx_cnt+1. rd_pending<=mem_rden.
- Completion: on the edge where rx_cnt becomes BYTES_PER_INSTR, the slot is free if instr_valid==0 or instr_ready==1.
  - Slot free: load the output with the complete word ({asm_word, mem_rdata}) and asm_pc, set instr_valid, clear iss_cnt/rx_cnt, stay in FILL.
  - Slot not free: go to FULL.
- FULL: no issue. On the first edge with a free slot, load the output, clear the counters, return to FILL.
- Output: instr_valid clears on handshake unless a new word loads on the same edge.
- Jump (jump_valid=1): priority over everything on that edge.
  - req_addr<=jump_addr; iss_cnt, rx_cnt, rd_pending cleared; state<=FILL; instr_valid<=0.
  - mem_rdata present in the jump cycle is discarded.
  - A handshake in the jump cycle still counts as delivered.
  - Fetch resumes from jump_addr on the next cycle.
- Reset (any time, asynchronous): state=FILL, req_addr=0, counters=0, rd_pending=0, asm_word=0, asm_pc=0, instr_valid=0, instr_data=0, instr_pc=0. mem_rden=1 in the first cycle after release unless jump_valid=1. A reset mid-assembly discards all progress.

## Timing
- Let N = BYTES_PER_INSTR and cycle 0 = first cycle after rst deasserts.
- Bytes are issued in cycles 0..N-1 and arrive in cycles 1..N. instr_valid rises in cycle N+1.
- Sustained throughput with instr_ready=1: one instruction per N+1 cycles.
  - The next instruction's first issue is in the cycle after the last capture.
  - instr_pc advances by N per instruction, mod 2^ADDR_W.
- Backpressure: while instr_valid=1 and instr_ready=0, the next word still fully assembles, then holds in FULL. mem_rden stays 0 and the output stays stable.
- Jump in cycle J: first issue from jump_addr in cycle J+1; first new instr_valid in cycle J+N+2.
- Wrap: with ADDR_W=8, bytes at 0xFE,0xFF,0x00,0x01 form one instruction, instr_pc=0xFE.

## Test plan
- Reset release; memory byte i = i; N=4; instr_ready=1 -> instr_valid high in cycle 5 with instr_data=0x00010203, pc=0x00. Next word 0x04050607, pc=0x04, in cycle 10.
- Hold instr_ready=0 for 20 cycles after the first word -> the first word stays stable and mem_rden issues exactly 4 reads then stays 0. Raising ready delivers 0x04050607 on the following edge.
- jump_valid with jump_addr=0x80 while 2 bytes are assembled and a word is pending in the output -> instr_valid drops next edge. Next word 0x80818283, pc=0x80, appears 6 cycles after the jump cycle.
- jump_addr=0xFE -> instr_data=0xFEFF0001, instr_pc=0xFE; the following word has pc=0x02.
- rst asserted mid-assembly, asynchronously between edges -> all outputs 0 immediately. After release the sequence restarts at address 0 exactly as in the first scenario.
- Rerun with BYTES_PER_INSTR=2 and ADDR_W=10 -> 16-bit words every 3 cycles; pc wraps at 0x3FF.
